// File: rtl/pin_input_conditioner.sv
// Per-pin synchronizer plus debounce filter with registered edge pulses.
// Optional pin-change interrupt flags are enabled by defining PIN_CHANGE_IRQ_EN.
module pin_input_conditioner #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_raw,
    input  logic             bypass,
`ifdef PIN_CHANGE_IRQ_EN
    input  logic [WIDTH-1:0] irq_mask,
    input  logic             irq_clear,
    output logic             irq,
`endif
    output logic [WIDTH-1:0] pin_data,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain;
    logic [WIDTH-1:0]                  sync;
    logic [WIDTH-1:0]                  stable;
    logic [WIDTH-1:0]                  stable_next;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_next;

    assign sync     = sync_chain[SYNC_STAGES-1];
    assign pin_data = stable;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], pin_raw};
        end
    end

    // A single matching cycle drops the count, so only an unbroken mismatch run is accepted.
    always_comb begin
        stable_next = stable;
        cnt_next    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bypass) begin
                stable_next[i] = sync[i];
            end else if (sync[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_next[i] = sync[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable     <= '0;
            cnt        <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            changed    <= 1'b0;
        end else begin
            stable     <= stable_next;
            cnt        <= cnt_next;
            rise_pulse <= stable_next & ~stable;
            fall_pulse <= ~stable_next & stable;
            changed    <= |(stable_next ^ stable);
        end
    end

`ifdef PIN_CHANGE_IRQ_EN
    logic [WIDTH-1:0] pcif;
    logic [WIDTH-1:0] pcif_next;

    // New edges are OR-ed in after the clear, so an edge coincident with clear survives.
    assign pcif_next = (pcif & ~{WIDTH{irq_clear}}) | ((rise_pulse | fall_pulse) & irq_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            pcif <= '0;
            irq  <= 1'b0;
        end else begin
            pcif <= pcif_next;
            irq  <= |pcif_next;
        end
    end
`endif

endmodule

// File: tb/tb_pin_input_conditioner.sv
// Directed bench for pin_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Interrupt checks are compiled only when PIN_CHANGE_IRQ_EN is defined.
module tb_pin_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pin_raw;
    logic       bypass;
    logic [7:0] pin_data;
    logic [7:0] rise_pulse;
    logic [7:0] fall_pulse;
    logic       changed;
`ifdef PIN_CHANGE_IRQ_EN
    logic [7:0] irq_mask;
    logic       irq_clear;
    logic       irq;
`endif

    int checks_done = 0;
    int fail_cnt    = 0;

    always #5 clk = ~clk;

    pin_input_conditioner #(
        .WIDTH(8),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pin_raw(pin_raw),
        .bypass(bypass),
`ifdef PIN_CHANGE_IRQ_EN
        .irq_mask(irq_mask),
        .irq_clear(irq_clear),
        .irq(irq),
`endif
        .pin_data(pin_data),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .changed(changed)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_done++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance n cycles while OR-ing together every pulse seen.
    task automatic step_watch(input int n, output logic [7:0] acc_edge, output logic acc_chg);
        acc_edge = '0;
        acc_chg  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            acc_edge = acc_edge | rise_pulse | fall_pulse;
            acc_chg  = acc_chg | changed;
        end
    endtask

    logic [7:0] seen_edge;
    logic       seen_chg;

    initial begin
        reset   = 1'b1;
        pin_raw = 8'hFF;
        bypass  = 1'b0;
`ifdef PIN_CHANGE_IRQ_EN
        irq_mask  = 8'h01;
        irq_clear = 1'b0;
`endif
        step(3);
        check("reset_pin_data", pin_data, 8'h00);
        check("reset_rise", rise_pulse, 8'h00);
        check("reset_fall", fall_pulse, 8'h00);
        check("reset_changed", changed, 1'b0);
`ifdef PIN_CHANGE_IRQ_EN
        check("reset_irq", irq, 1'b0);
`endif

        // pins held high through reset are re-accepted 5 edges after the first sample
        reset = 1'b0;
        step(5);
        check("post_reset_pending", pin_data, 8'h00);
        step(1);
        check("post_reset_data", pin_data, 8'hFF);
        check("post_reset_rise", rise_pulse, 8'hFF);
        check("post_reset_changed", changed, 1'b1);
        step(1);
        check("post_reset_rise_end", rise_pulse, 8'h00);
        check("post_reset_chg_end", changed, 1'b0);

        pin_raw = 8'h00;
        step(6);
        check("all_fall_data", pin_data, 8'h00);
        check("all_fall_pulse", fall_pulse, 8'hFF);
        step(1);
        check("all_fall_end", fall_pulse, 8'h00);

        // clean step on bit 0
        pin_raw = 8'h01;
        step(5);
        check("step0_pending", pin_data, 8'h00);
        step(1);
        check("step0_data", pin_data, 8'h01);
        check("step0_rise", rise_pulse, 8'h01);
        check("step0_changed", changed, 1'b1);
        step(1);
        check("step0_rise_end", rise_pulse, 8'h00);
        check("step0_hold", pin_data, 8'h01);
        pin_raw = 8'h00;
        step(5);
        check("step0_fall_pending", pin_data, 8'h01);
        step(1);
        check("step0_fall_data", pin_data, 8'h00);
        check("step0_fall", fall_pulse, 8'h01);
        step(1);
        check("step0_fall_end", fall_pulse, 8'h00);

        // glitch of 3 cycles on bit 3 is rejected
        pin_raw = 8'h08;
        step(3);
        pin_raw = 8'h00;
        step_watch(10, seen_edge, seen_chg);
        check("glitch3_data", pin_data, 8'h00);
        check("glitch3_pulses", seen_edge, 8'h00);
        check("glitch3_changed", seen_chg, 1'b0);

        // exactly 4 cycles is accepted
        pin_raw = 8'h08;
        step(4);
        pin_raw = 8'h00;
        step(1);
        check("pulse4_pending", pin_data, 8'h00);
        step(1);
        check("pulse4_data", pin_data, 8'h08);
        check("pulse4_rise", rise_pulse, 8'h08);
        step(10);
        check("pulse4_back_low", pin_data, 8'h00);

        // chatter 1,1,0,1,1,1,1 on bit 5
        pin_raw = 8'h20; step(1);
        pin_raw = 8'h20; step(1);
        pin_raw = 8'h00; step(1);
        pin_raw = 8'h20; step(4);
        step(1);
        check("chatter_pending", pin_data, 8'h00);
        step(1);
        check("chatter_data", pin_data, 8'h20);
        check("chatter_rise", rise_pulse, 8'h20);
        pin_raw = 8'h00;
        step(10);
        check("chatter_back_low", pin_data, 8'h00);

        // bypass: visible 2 edges after the sampling edge
        bypass  = 1'b1;
        pin_raw = 8'hA5;
        step(2);
        check("bypass_pending", pin_data, 8'h00);
        step(1);
        check("bypass_data", pin_data, 8'hA5);
        check("bypass_rise", rise_pulse, 8'hA5);

        // bits 1 and 6 change together: two rise bits, one changed pulse
        pin_raw = 8'hE7;
        step_watch(3, seen_edge, seen_chg);
        check("indep_data", pin_data, 8'hE7);
        check("indep_rise", rise_pulse, 8'h42);
        check("indep_changed", changed, 1'b1);
        step(1);
        check("indep_changed_end", changed, 1'b0);

        bypass  = 1'b0;
        pin_raw = 8'h00;
        step(6);
        check("unbypass_fall", fall_pulse, 8'hE7);
        check("unbypass_data", pin_data, 8'h00);
        step(2);

`ifdef PIN_CHANGE_IRQ_EN
        pin_raw = 8'h01;
        step(6);
        check("irq_rise0_pulse", rise_pulse, 8'h01);
        check("irq_not_yet", irq, 1'b0);
        step(1);
        check("irq_set", irq, 1'b1);
        step(3);
        check("irq_sticky", irq, 1'b1);
        irq_clear = 1'b1;
        step(1);
        irq_clear = 1'b0;
        check("irq_cleared", irq, 1'b0);

        pin_raw = 8'h03;
        step_watch(8, seen_edge, seen_chg);
        check("irq_bit1_edge", seen_edge, 8'h02);
        check("irq_masked", irq, 1'b0);

        pin_raw = 8'h02;
        step(6);
        check("irq_fall0_pulse", fall_pulse, 8'h01);
        pin_raw = 8'h03;
        step(1);
        check("irq_fall0_set", irq, 1'b1);
        step(5);
        check("irq_rise0_again", rise_pulse, 8'h01);
        irq_clear = 1'b1;
        step(1);
        irq_clear = 1'b0;
        check("irq_clear_vs_edge", irq, 1'b1);
        irq_clear = 1'b1;
        step(1);
        irq_clear = 1'b0;
        check("irq_final_clear", irq, 1'b0);
`endif

        // reset mid-operation forces everything back to 0
        pin_raw = 8'hFF;
        step(8);
        reset = 1'b1;
        step(1);
        check("midreset_data", pin_data, 8'h00);
        check("midreset_changed", changed, 1'b0);
        reset = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
